// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: FSM states, widths and
// the most-negative-dividend constant used for overflow detection.
package div_pkg;

  localparam int DIV_N  = 8;
  localparam int DIV_DW = 2 * DIV_N;
  localparam int DIV_RW = DIV_N + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Most negative 2n-bit two's complement value, right-aligned in 64 bits.
  function automatic logic [63:0] ovf_const(input int n);
    return 64'd1 << (2 * n - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes, purely combinational.
// Zero latency; no handshake, the caller decides when to register the result.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   rem_in,
  input  logic         dvd_bit,
  input  logic [N-1:0] dsr_mag,
  output logic [N:0]   rem_out,
  output logic         q_bit
);

  logic [N+1:0] shifted;
  logic [N+1:0] diff;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {2'b00, dsr_mag};
    // Partial remainder stays below the divisor, so bit N+1 of the
    // difference is a reliable borrow indicator.
    q_bit   = ~diff[N+1];
    rem_out = q_bit ? diff[N:0] : shifted[N:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Signed 2N/N iterative divider, 2N+1 clocks per op; start is ignored while busy
// (no queueing). Optional SEQ_DIVIDER_DBZ_EN adds a divide-by-zero fast path and dbz flag.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*N-1:0]    dividend,
  input  logic [N-1:0]      divisor,
  output logic              busy,
  output logic              done,
  output logic [2*N-1:0]    quotient,
  output logic [N-1:0]      remainder,
  output logic              ovf
`ifdef SEQ_DIVIDER_DBZ_EN
  ,
  output logic              dbz
`endif
);

  localparam int DW = 2 * N;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] OVF_DVD = DW'(ovf_const(N));

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N:0]    rem;
  logic [DW-1:0] dvd;      // dividend magnitude, becomes quotient magnitude
  logic [N-1:0]  dsr_mag;
  logic          sgn_dd;
  logic          sgn_dv;
  logic          ovf_pend;
`ifdef SEQ_DIVIDER_DBZ_EN
  logic          dbz_pend;
`endif

  logic [DW-1:0] dd_mag;
  logic [N-1:0]  dv_mag;
  logic [N:0]    rem_nxt;
  logic          q_bit;
  logic [DW-1:0] q_fix;
  logic [N-1:0]  r_fix;

  always_comb begin
    dd_mag = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
    dv_mag = divisor[N-1]   ? (~divisor + 1'b1)  : divisor;
    q_fix  = (sgn_dd ^ sgn_dv) ? (~dvd + 1'b1) : dvd;
    r_fix  = sgn_dd ? (~rem[N-1:0] + 1'b1) : rem[N-1:0];
  end

  div_step #(.N(N)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[DW-1]),
    .dsr_mag (dsr_mag),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rem       <= '0;
      dvd       <= '0;
      dsr_mag   <= '0;
      sgn_dd    <= 1'b0;
      sgn_dv    <= 1'b0;
      ovf_pend  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
`ifdef SEQ_DIVIDER_DBZ_EN
      dbz_pend  <= 1'b0;
      dbz       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            dvd      <= dd_mag;
            dsr_mag  <= dv_mag;
            sgn_dd   <= dividend[DW-1];
            sgn_dv   <= divisor[N-1];
            rem      <= '0;
            cnt      <= CW'(DW - 1);
            busy     <= 1'b1;
            ovf_pend <= (dividend == OVF_DVD) && (divisor == '1);
`ifdef SEQ_DIVIDER_DBZ_EN
            dbz      <= 1'b0;
            dbz_pend <= (divisor == '0);
            state    <= (divisor == '0) ? ST_FIX : ST_CALC;
`else
            state    <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          rem <= rem_nxt;
          dvd <= {dvd[DW-2:0], q_bit};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= ST_FIX;
        end
        ST_FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
`ifdef SEQ_DIVIDER_DBZ_EN
          if (dbz_pend) begin
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b1;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
            ovf       <= ovf_pend;
          end
`else
          quotient  <= q_fix;
          remainder <= r_fix;
          ovf       <= ovf_pend;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
